// File: rtl/fir_axi_pkg.sv
// +--------------------------------------------------------------------------+
// | fir_axi_pkg : shared types and constants for the FIR AXI4-Lite config.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package fir_axi_pkg;

  localparam int FIR_DATA_WIDTH = 32;

  localparam logic [3:0] REGION_CTRL = 4'h0;
  localparam logic [3:0] REGION_TAP  = 4'h1;
  localparam logic [3:0] REGION_DATA = 4'h2;
  localparam logic [3:0] REGION_BRAM = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_D = 3'd3,
    ST_RSP  = 3'd4
  } cfg_mst_state_e;

  function automatic logic [3:0] addr_region(input logic [31:0] addr);
    return addr[31:28];
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite_fir_cfg_master.sv
// +--------------------------------------------------------------------------+
// | axi4_lite_fir_cfg_master : one-at-a-time command to AXI4-Lite AR/R, AW+W |
// | Revision                 : 1.0                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module axi4_lite_fir_cfg_master
  import fir_axi_pkg::*;
#(
  parameter int pDATA_WIDTH    = FIR_DATA_WIDTH,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   in_cmd_valid,
  input  logic                   in_cmd_write,
  input  logic [pDATA_WIDTH-1:0] in_cmd_addr,
  input  logic [pDATA_WIDTH-1:0] in_cmd_wdata,
  output logic                   out_cmd_ready,
  output logic                   out_rsp_valid,
  output logic [pDATA_WIDTH-1:0] out_rsp_rdata,
  output logic                   out_rsp_err,
  input  logic                   in_rsp_ready,
  output logic [pDATA_WIDTH-1:0] out_m_araddr,
  output logic                   out_m_arvalid,
  input  logic                   in_m_arready,
  input  logic [pDATA_WIDTH-1:0] in_m_rdata,
  input  logic                   in_m_rvalid,
  output logic                   out_m_rready,
  output logic [pDATA_WIDTH-1:0] out_m_awaddr,
  output logic                   out_m_awvalid,
  input  logic                   in_m_awready,
  output logic [pDATA_WIDTH-1:0] out_m_wdata,
  output logic                   out_m_wvalid,
  input  logic                   in_m_wready
);

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  cfg_mst_state_e             state, state_nxt;
  logic [TIMEOUT_WIDTH-1:0]   cnt, cnt_nxt, cnt_inc;
  logic                       aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic                       cmd_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
  logic [pDATA_WIDTH-1:0]     rsp_rdata_nxt, araddr_nxt, awaddr_nxt, wdata_nxt;
  logic                       arvalid_nxt, rready_nxt, awvalid_nxt, wvalid_nxt;
  logic                       aw_hs, w_hs, ar_hs, r_hs, abort;

  assign aw_hs   = out_m_awvalid && in_m_awready;
  assign w_hs    = out_m_wvalid  && in_m_wready;
  assign ar_hs   = out_m_arvalid && in_m_arready;
  assign r_hs    = in_m_rvalid   && out_m_rready;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      out_cmd_ready <= 1'b1;
      out_rsp_valid <= 1'b0;
      out_rsp_rdata <= '0;
      out_rsp_err   <= 1'b0;
      out_m_araddr  <= '0;
      out_m_arvalid <= 1'b0;
      out_m_rready  <= 1'b0;
      out_m_awaddr  <= '0;
      out_m_awvalid <= 1'b0;
      out_m_wdata   <= '0;
      out_m_wvalid  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      aw_done       <= aw_done_nxt;
      w_done        <= w_done_nxt;
      out_cmd_ready <= cmd_ready_nxt;
      out_rsp_valid <= rsp_valid_nxt;
      out_rsp_rdata <= rsp_rdata_nxt;
      out_rsp_err   <= rsp_err_nxt;
      out_m_araddr  <= araddr_nxt;
      out_m_arvalid <= arvalid_nxt;
      out_m_rready  <= rready_nxt;
      out_m_awaddr  <= awaddr_nxt;
      out_m_awvalid <= awvalid_nxt;
      out_m_wdata   <= wdata_nxt;
      out_m_wvalid  <= wvalid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    cmd_ready_nxt = out_cmd_ready;
    rsp_valid_nxt = out_rsp_valid;
    rsp_rdata_nxt = out_rsp_rdata;
    rsp_err_nxt   = out_rsp_err;
    araddr_nxt    = out_m_araddr;
    arvalid_nxt   = out_m_arvalid;
    rready_nxt    = out_m_rready;
    awaddr_nxt    = out_m_awaddr;
    awvalid_nxt   = out_m_awvalid;
    wdata_nxt     = out_m_wdata;
    wvalid_nxt    = out_m_wvalid;
    abort         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_cmd_valid && out_cmd_ready) begin
          cmd_ready_nxt = 1'b0;
          cnt_nxt       = '0;
          aw_done_nxt   = 1'b0;
          w_done_nxt    = 1'b0;
          if (in_cmd_write) begin
            awaddr_nxt  = in_cmd_addr;
            wdata_nxt   = in_cmd_wdata;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = ST_WR;
          end else begin
            araddr_nxt  = in_cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = ST_RD_A;
          end
        end
      end
      ST_WR: begin
        // AW and W complete independently; either order or the same edge.
        if (aw_hs) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b0;
          state_nxt     = ST_RSP;
        end else if (aw_hs || w_hs) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_RD_A: begin
        if (ar_hs) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = ST_RD_D;
        end else if (cnt == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_RD_D: begin
        if (r_hs) begin
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = in_m_rdata;
          rsp_err_nxt   = 1'b0;
          state_nxt     = ST_RSP;
        end else if (cnt == CNT_LAST) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_RSP: begin
        if (in_rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Stalled phase: withdraw every request even though no handshake happened.
    if (abort) begin
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;
      rsp_valid_nxt = 1'b1;
      rsp_rdata_nxt = '0;
      rsp_err_nxt   = 1'b1;
      state_nxt     = ST_RSP;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_fir_cfg_master.sv
// +--------------------------------------------------------------------------+
// | tb_axi4_lite_fir_cfg_master : vectors, corner sequences, random + model  |
// | Revision                    : 1.0                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_axi4_lite_fir_cfg_master;
  import fir_axi_pkg::*;

  localparam int T     = 200;
  localparam int NEVER = 1000;

  logic        aclk, aresetn;
  logic        in_cmd_valid, in_cmd_write, out_cmd_ready;
  logic [31:0] in_cmd_addr, in_cmd_wdata;
  logic        out_rsp_valid, out_rsp_err, in_rsp_ready;
  logic [31:0] out_rsp_rdata;
  logic [31:0] out_m_araddr, in_m_rdata, out_m_awaddr, out_m_wdata;
  logic        out_m_arvalid, in_m_arready, in_m_rvalid, out_m_rready;
  logic        out_m_awvalid, in_m_awready, out_m_wvalid, in_m_wready;

  axi4_lite_fir_cfg_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_cmd_valid(in_cmd_valid), .in_cmd_write(in_cmd_write),
    .in_cmd_addr(in_cmd_addr), .in_cmd_wdata(in_cmd_wdata),
    .out_cmd_ready(out_cmd_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_rdata(out_rsp_rdata),
    .out_rsp_err(out_rsp_err), .in_rsp_ready(in_rsp_ready),
    .out_m_araddr(out_m_araddr), .out_m_arvalid(out_m_arvalid), .in_m_arready(in_m_arready),
    .in_m_rdata(in_m_rdata), .in_m_rvalid(in_m_rvalid), .out_m_rready(out_m_rready),
    .out_m_awaddr(out_m_awaddr), .out_m_awvalid(out_m_awvalid), .in_m_awready(in_m_awready),
    .out_m_wdata(out_m_wdata), .out_m_wvalid(out_m_wvalid), .in_m_wready(in_m_wready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Responder configuration, written only by the stimulus process.
  int          cfg_aw_d = 0, cfg_w_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  bit          cfg_late = 1'b0;
  logic [31:0] cfg_rdata = '0;

  // Responder: each ready/valid asserts after a configured number of cycles.
  int aw_c = 0, w_c = 0, ar_c = 0, r_c = 0;
  initial begin
    in_m_awready = 1'b0; in_m_wready = 1'b0; in_m_arready = 1'b0;
    in_m_rvalid  = 1'b0; in_m_rdata  = '0;
  end
  always @(negedge aclk) begin
    if (out_m_awvalid) begin in_m_awready = (aw_c == cfg_aw_d); aw_c++; end
    else begin in_m_awready = 1'b0; aw_c = 0; end
    if (out_m_wvalid) begin in_m_wready = (w_c == cfg_w_d); w_c++; end
    else begin in_m_wready = 1'b0; w_c = 0; end
    if (out_m_arvalid) begin in_m_arready = (ar_c == cfg_ar_d); ar_c++; end
    else begin in_m_arready = 1'b0; ar_c = 0; end
    if (out_m_rready) begin in_m_rvalid = (r_c == cfg_r_d); r_c++; end
    else begin in_m_rvalid = cfg_late; r_c = 0; end
    in_m_rdata = in_m_rvalid ? cfg_rdata : ~cfg_rdata;
  end

  // Bus monitor: handshake counts, captured payloads, protocol violations.
  int          cyc = 0, n_aw = 0, n_w = 0, n_ar = 0, n_r = 0, n_viol = 0;
  logic [31:0] hs_awaddr = '0, hs_wdata = '0, hs_araddr = '0;
  logic        p_aw_hs = 0, p_w_hs = 0, p_ar_hs = 0, p_r_hs = 0;
  logic        p_aw_st = 0, p_w_st = 0, p_ar_st = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (aresetn) begin
      if (out_m_awvalid && in_m_awready) begin n_aw <= n_aw + 1; hs_awaddr <= out_m_awaddr; end
      if (out_m_wvalid && in_m_wready)   begin n_w  <= n_w + 1;  hs_wdata  <= out_m_wdata;  end
      if (out_m_arvalid && in_m_arready) begin n_ar <= n_ar + 1; hs_araddr <= out_m_araddr; end
      if (in_m_rvalid && out_m_rready)   n_r <= n_r + 1;
      if ((p_aw_hs && out_m_awvalid) || (p_w_hs && out_m_wvalid) ||
          (p_ar_hs && out_m_arvalid) || (p_r_hs && out_m_rready) ||
          (p_aw_st && out_m_awvalid && out_m_awaddr != p_awaddr) ||
          (p_w_st && out_m_wvalid && out_m_wdata != p_wdata) ||
          (p_ar_st && out_m_arvalid && out_m_araddr != p_araddr))
        n_viol <= n_viol + 1;
    end
    p_aw_hs  <= out_m_awvalid && in_m_awready;
    p_w_hs   <= out_m_wvalid && in_m_wready;
    p_ar_hs  <= out_m_arvalid && in_m_arready;
    p_r_hs   <= in_m_rvalid && out_m_rready;
    p_aw_st  <= out_m_awvalid && !in_m_awready;
    p_w_st   <= out_m_wvalid && !in_m_wready;
    p_ar_st  <= out_m_arvalid && !in_m_arready;
    p_awaddr <= out_m_awaddr;
    p_wdata  <= out_m_wdata;
    p_araddr <= out_m_araddr;
  end

  // Reference model: each phase must progress within T-1 idle cycles of the
  // previous progress point; otherwise the response arrives T cycles after it.
  task automatic model(input bit wr, input int a, input int w, input int ar, input int r,
                       input logic [31:0] rv, output int lat, output bit err,
                       output logic [31:0] data, output int e_aw, output int e_w,
                       output int e_ar, output int e_r);
    int lo, hi;
    e_aw = 0; e_w = 0; e_ar = 0; e_r = 0; data = '0; err = 1'b0;
    if (wr) begin
      lo = (a < w) ? a : w;
      hi = (a < w) ? w : a;
      if (lo > T - 1) begin
        lat = 1 + T; err = 1'b1;
      end else begin
        e_aw = (a == lo); e_w = (w == lo);
        if (a == w)                  lat = 2 + lo;
        else if (hi - lo - 1 <= T - 1) begin lat = 2 + hi; e_aw = 1; e_w = 1; end
        else begin lat = 2 + lo + T; err = 1'b1; end
      end
    end else begin
      if (ar > T - 1) begin
        lat = 1 + T; err = 1'b1;
      end else if (r > T - 1) begin
        lat = 2 + ar + T; err = 1'b1; e_ar = 1;
      end else begin
        lat = 3 + ar + r; e_ar = 1; e_r = 1; data = rv;
      end
    end
  endtask

  task automatic wait_cmd_ready(input string tag);
    int k = 0;
    while (!out_cmd_ready && k < 50) begin @(negedge aclk); k++; end
    chk({tag, "_cmd_ready"}, {31'd0, out_cmd_ready}, 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input int t0);
    while (!out_rsp_valid && (cyc - t0) < NEVER) @(negedge aclk);
    chk({tag, "_rsp_seen"}, {31'd0, out_rsp_valid}, 32'd1);
  endtask

  // Full transaction plus comparison against the model and optional table values.
  task automatic run_cmd(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input int a, input int w, input int ar,
                         input int r, input bit late, input logic [31:0] rv,
                         input bit use_exp, input logic [31:0] x_rd, input bit x_err,
                         input int x_lat);
    int t0, lat, m_lat, e_aw, e_w, e_ar, e_r;
    int s_aw, s_w, s_ar, s_r, s_v;
    bit m_err;
    logic [31:0] m_rd;
    cfg_aw_d = a; cfg_w_d = w; cfg_ar_d = ar; cfg_r_d = r; cfg_late = late; cfg_rdata = rv;
    s_aw = n_aw; s_w = n_w; s_ar = n_ar; s_r = n_r; s_v = n_viol;
    in_cmd_valid = 1'b1; in_cmd_write = wr; in_cmd_addr = addr; in_cmd_wdata = wd;
    wait_cmd_ready(tag);
    t0 = cyc;
    @(negedge aclk);
    in_cmd_valid = 1'b0;
    wait_rsp(tag, t0);
    lat = cyc - t0;
    model(wr, a, w, ar, r, rv, m_lat, m_err, m_rd, e_aw, e_w, e_ar, e_r);
    chk({tag, "_latency"}, lat, m_lat);
    chk({tag, "_err"}, {31'd0, out_rsp_err}, {31'd0, m_err});
    chk({tag, "_rdata"}, out_rsp_rdata, m_rd);
    if (use_exp) begin
      chk({tag, "_tbl_latency"}, lat, x_lat);
      chk({tag, "_tbl_err"}, {31'd0, out_rsp_err}, {31'd0, x_err});
      chk({tag, "_tbl_rdata"}, out_rsp_rdata, x_rd);
    end
    chk({tag, "_n_aw"}, n_aw - s_aw, e_aw);
    chk({tag, "_n_w"},  n_w - s_w,   e_w);
    chk({tag, "_n_ar"}, n_ar - s_ar, e_ar);
    chk({tag, "_n_r"},  n_r - s_r,   e_r);
    chk({tag, "_protocol"}, n_viol - s_v, 0);
    if (n_aw - s_aw == 1) chk({tag, "_awaddr"}, hs_awaddr, addr);
    if (n_w - s_w == 1)   chk({tag, "_wdata"}, hs_wdata, wd);
    if (n_ar - s_ar == 1) chk({tag, "_araddr"}, hs_araddr, addr);
    in_rsp_ready = 1'b1;
    @(negedge aclk);
    in_rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, {31'd0, out_rsp_valid}, 32'd0);
    chk({tag, "_ready_again"}, {31'd0, out_cmd_ready}, 32'd1);
    cfg_late = 1'b0;
  endtask

  typedef struct {
    bit wr; logic [31:0] addr; logic [31:0] wd;
    int aw_d; int w_d; int ar_d; int r_d; bit late; logic [31:0] rv;
    logic [31:0] x_rd; bit x_err; int x_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [3:0] regions[4];
    int t0;
    regions[0] = REGION_CTRL; regions[1] = REGION_TAP;
    regions[2] = REGION_DATA; regions[3] = REGION_BRAM;

    vecs[0]  = '{1, 32'h1000_0000, 32'h0000_000B, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 2};
    vecs[1]  = '{1, 32'h2000_0000, 32'h0000_0040, 0, 3, 0, 0, 0, 32'h0, 32'h0, 0, 5};
    vecs[2]  = '{0, 32'h3000_0004, 32'h0, 0, 0, 2, 4, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 9};
    vecs[3]  = '{0, 32'h0000_0000, 32'h0, 0, 0, NEVER, 0, 0, 32'h1111_2222, 32'h0, 1, 201};
    vecs[4]  = '{1, 32'h3000_0010, 32'h0000_0055, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 2};
    vecs[5]  = '{0, 32'h1000_0000, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0040, 32'h0000_0040, 0, 3};
    vecs[6]  = '{1, 32'h2000_0008, 32'hCAFE_0001, 199, 0, 0, 0, 0, 32'h0, 32'h0, 0, 201};
    vecs[7]  = '{0, 32'h3000_0008, 32'h0, 0, 0, 199, 0, 0, 32'hA5A5_0001, 32'hA5A5_0001, 0, 202};
    vecs[8]  = '{0, 32'h3000_000C, 32'h0, 0, 0, 200, 0, 0, 32'h5A5A_0002, 32'h0, 1, 201};
    vecs[9]  = '{0, 32'h0000_0004, 32'h0, 0, 0, 0, NEVER, 1, 32'h7777_7777, 32'h0, 1, 202};
    vecs[10] = '{1, 32'h1000_0004, 32'h0000_0003, 3, 204, 0, 0, 0, 32'h0, 32'h0, 1, 205};
    vecs[11] = '{1, 32'h1000_0008, 32'h0000_0004, 3, 203, 0, 0, 0, 32'h0, 32'h0, 0, 205};

    aresetn = 1'b0; in_cmd_valid = 1'b0; in_cmd_write = 1'b0;
    in_cmd_addr = '0; in_cmd_wdata = '0; in_rsp_ready = 1'b0;
    repeat (3) @(negedge aclk);
    chk("reset_cmd_ready", {31'd0, out_cmd_ready}, 32'd1);
    chk("reset_valids", {27'd0, out_m_awvalid, out_m_wvalid, out_m_arvalid, out_m_rready,
                         out_rsp_valid}, 32'd0);
    chk("reset_rsp", {31'd0, out_rsp_err} | out_rsp_rdata, 32'd0);
    chk("reset_addr", out_m_awaddr | out_m_araddr | out_m_wdata, 32'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 12; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].aw_d,
              vecs[i].w_d, vecs[i].ar_d, vecs[i].r_d, vecs[i].late, vecs[i].rv,
              1'b1, vecs[i].x_rd, vecs[i].x_err, vecs[i].x_lat);

    // Response held back while a new command waits.
    cfg_aw_d = 0; cfg_w_d = 0; cfg_ar_d = 0; cfg_r_d = 0; cfg_rdata = 32'h1234_5678;
    in_cmd_valid = 1'b1; in_cmd_write = 1'b1; in_cmd_addr = 32'h2000_0000; in_cmd_wdata = 32'h9;
    wait_cmd_ready("hold");
    t0 = cyc;
    @(negedge aclk);
    in_cmd_write = 1'b0; in_cmd_addr = 32'h3000_0020;
    wait_rsp("hold", t0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold_rsp_valid_%0d", i), {31'd0, out_rsp_valid}, 32'd1);
      chk($sformatf("hold_rsp_data_%0d", i), out_rsp_rdata | {31'd0, out_rsp_err}, 32'd0);
      chk($sformatf("hold_cmd_ready_%0d", i), {31'd0, out_cmd_ready}, 32'd0);
      @(negedge aclk);
    end
    in_rsp_ready = 1'b1;
    @(negedge aclk);
    in_rsp_ready = 1'b0;
    chk("hold_ready_after_rsp", {31'd0, out_cmd_ready}, 32'd1);
    t0 = cyc;
    @(negedge aclk);
    in_cmd_valid = 1'b0;
    chk("hold_accept_arvalid", {31'd0, out_m_arvalid}, 32'd1);
    chk("hold_accept_araddr", out_m_araddr, 32'h3000_0020);
    wait_rsp("hold_read", t0);
    chk("hold_read_latency", cyc - t0, 3);
    chk("hold_read_rdata", out_rsp_rdata, 32'h1234_5678);
    in_rsp_ready = 1'b1;
    @(negedge aclk);
    in_rsp_ready = 1'b0;

    // Reset in the middle of a write.
    cfg_aw_d = NEVER; cfg_w_d = NEVER;
    in_cmd_valid = 1'b1; in_cmd_write = 1'b1; in_cmd_addr = 32'h0000_0000; in_cmd_wdata = 32'h1;
    wait_cmd_ready("rst");
    @(negedge aclk);
    in_cmd_valid = 1'b0;
    chk("rst_awvalid_before", {31'd0, out_m_awvalid}, 32'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    chk("rst_valids", {28'd0, out_m_awvalid, out_m_wvalid, out_m_arvalid, out_rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, out_cmd_ready}, 32'd1);
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 30; i++) begin
      int d[4];
      for (int j = 0; j < 4; j++)
        d[j] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(195, 205))
                                           : int'($urandom_range(0, 4));
      run_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
              {regions[$urandom_range(0, 3)], 28'($urandom)}, $urandom,
              d[0], d[1], d[2], d[3], 1'b0, $urandom, 1'b0, 32'h0, 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
